// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types and BCD helpers for the two-digit display counter
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_pair_t;

  // Two-digit BCD increment; 99 rolls to 00 (never reached inside legal bounds).
  function automatic bcd_pair_t bcd_inc2(bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  // Two-digit BCD decrement; 00 rolls to 99 (never reached inside legal bounds).
  function automatic bcd_pair_t bcd_dec2(bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.ones == 4'd0) begin
      r.ones = 4'd9;
      r.tens = (v.tens == 4'd0) ? 4'd9 : v.tens - 4'd1;
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

  // Decimal constant to a BCD pair, used for the bound parameters.
  function automatic bcd_pair_t to_bcd2(int unsigned v);
    bcd_pair_t r;
    r.tens = 4'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

  // Parameter legality, evaluated at elaboration by the top.
  function automatic bit params_ok(int tick_div, int min_val, int max_val, int wrap);
    return (tick_div >= 2) && (min_val >= 0) && (min_val <= 98) &&
           (min_val < max_val) && (max_val <= 99) && (wrap >= 0) && (wrap <= 1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser plus rising-edge one-cycle pulse
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronise the raw level, then remember the last synchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/bcd_count_seq_ctrl.sv
// rtl/bcd_count_seq_ctrl.sv - run/pause/clear controller for the bounded two-digit BCD counter
module bcd_count_seq_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int MIN_VAL  = 5,
  parameter int MAX_VAL  = 14,
  parameter int WRAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       up_dn,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       blank,
  output logic       running,
  output logic       done
);

  localparam int        PW      = $clog2(TICK_DIV);
  localparam bcd_pair_t MIN_BCD = to_bcd2(MIN_VAL);
  localparam bcd_pair_t MAX_BCD = to_bcd2(MAX_VAL);

  if (!params_ok(TICK_DIV, MIN_VAL, MAX_VAL, WRAP)) begin : g_bad_params
    $error("bcd_count_seq_ctrl: illegal TICK_DIV/MIN_VAL/MAX_VAL/WRAP combination");
  end

  logic sta_p, stp_p, clr_p;

  btn_sync_edge u_start (.clk(clk), .rst(rst), .btn_i(btn_start), .pulse_o(sta_p));
  btn_sync_edge u_stop  (.clk(clk), .rst(rst), .btn_i(btn_stop),  .pulse_o(stp_p));
  btn_sync_edge u_clear (.clk(clk), .rst(rst), .btn_i(btn_clear), .pulse_o(clr_p));

  state_e         state_q, state_d;
  bcd_pair_t      cnt_q, cnt_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           blank_q, running_q, done_q;
  logic           tick;
  logic           hit;

  assign tick = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

  // Next state, next count and prescaler; clear beats stop, stop beats start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    if (clr_p) begin
      state_d = IDLE;
      cnt_d   = MIN_BCD;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (sta_p && !stp_p) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            if (up_dn) begin
              if (cnt_q != MAX_BCD)  cnt_d = bcd_inc2(cnt_q);
              else if (WRAP != 0)    cnt_d = MIN_BCD;
              else                   hit   = 1'b1;
            end else begin
              if (cnt_q != MIN_BCD)  cnt_d = bcd_dec2(cnt_q);
              else if (WRAP != 0)    cnt_d = MAX_BCD;
              else                   hit   = 1'b1;
            end
          end
          // A stop on the tick edge still lets the count step, then pauses.
          if (stp_p)    state_d = PAUSE;
          else if (hit) state_d = DONE;
        end
        DONE: ;
      endcase
    end
    // Prescaler only advances while staying in RUN, so every entry restarts at 0.
    if (state_q != RUN || state_d != RUN || tick) presc_d = '0;
    else                                          presc_d = presc_q + PW'(1);
  end

  // State, count, prescaler and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= MIN_BCD;
      presc_q   <= '0;
      blank_q   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      blank_q   <= (state_d == IDLE);
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign tens    = cnt_q.tens;
  assign ones    = cnt_q.ones;
  assign blank   = blank_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_count_seq_ctrl.sv
// tb/tb_bcd_count_seq_ctrl.sv - scoreboard bench for bcd_count_seq_ctrl, WRAP=0 and WRAP=1 side by side
module tb_bcd_count_seq_ctrl;

  localparam int TD   = 4;
  localparam int MINV = 5;
  localparam int MAXV = 14;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank;
    logic       running;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic rst, btn_start, btn_stop, btn_clear, up_dn;

  logic [3:0] d_ones    [2];
  logic [3:0] d_tens    [2];
  logic       d_blank   [2];
  logic       d_running [2];
  logic       d_done    [2];

  bcd_count_seq_ctrl #(.TICK_DIV(TD), .MIN_VAL(MINV), .MAX_VAL(MAXV), .WRAP(0)) u_dut_nowrap (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
    .up_dn(up_dn), .ones(d_ones[0]), .tens(d_tens[0]), .blank(d_blank[0]),
    .running(d_running[0]), .done(d_done[0])
  );

  bcd_count_seq_ctrl #(.TICK_DIV(TD), .MIN_VAL(MINV), .MAX_VAL(MAXV), .WRAP(1)) u_dut_wrap (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
    .up_dn(up_dn), .ones(d_ones[1]), .tens(d_tens[1]), .blank(d_blank[1]),
    .running(d_running[1]), .done(d_done[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  bit started = 1'b0;

  obs_t exp_q0[$];
  obs_t exp_q1[$];

  // Reference model: decimal value, abstract state, cycles spent in RUN.
  int m_st  [2];
  int m_val [2];
  int m_cnt [2];
  // Button level samples at the last three edges: [0] newest.
  bit [2:0] h_sta, h_stp, h_clr;
  bit e_sta, e_stp, e_clr;

  function automatic obs_t model_obs(int w);
    obs_t o;
    o.tens    = 4'(m_val[w] / 10);
    o.ones    = 4'(m_val[w] % 10);
    o.blank   = (m_st[w] == S_IDLE);
    o.running = (m_st[w] == S_RUN);
    o.done    = (m_st[w] == S_DONE);
    return o;
  endfunction

  function automatic obs_t dut_obs(int w);
    return {d_tens[w], d_ones[w], d_blank[w], d_running[w], d_done[w]};
  endfunction

  task automatic model_step(int w, bit clr, bit stp, bit sta, bit up);
    bit tk, hit;
    tk  = (m_st[w] == S_RUN) && (m_cnt[w] == TD - 1);
    hit = 1'b0;
    if (clr) begin
      m_st[w] = S_IDLE; m_val[w] = MINV; m_cnt[w] = 0;
      return;
    end
    case (m_st[w])
      S_IDLE, S_PAUSE: if (sta && !stp) begin m_st[w] = S_RUN; m_cnt[w] = 0; end
      S_RUN: begin
        if (tk) begin
          if (up) begin
            if (m_val[w] < MAXV) m_val[w] = m_val[w] + 1;
            else if (w == 1)     m_val[w] = MINV;
            else                 hit = 1'b1;
          end else begin
            if (m_val[w] > MINV) m_val[w] = m_val[w] - 1;
            else if (w == 1)     m_val[w] = MAXV;
            else                 hit = 1'b1;
          end
        end
        m_cnt[w] = tk ? 0 : m_cnt[w] + 1;
        if (stp)      begin m_st[w] = S_PAUSE; m_cnt[w] = 0; end
        else if (hit) begin m_st[w] = S_DONE;  m_cnt[w] = 0; end
      end
      default: ;
    endcase
  endtask

  // Advance the model on each clock edge and queue what each DUT should show.
  always @(posedge clk) begin
    if (rst) begin
      h_sta = '0; h_stp = '0; h_clr = '0;
      for (int w = 0; w < 2; w++) begin
        m_st[w] = S_IDLE; m_val[w] = MINV; m_cnt[w] = 0;
      end
    end else begin
      // A rise sampled two edges ago takes effect on this edge.
      e_sta = h_sta[1] && !h_sta[2];
      e_stp = h_stp[1] && !h_stp[2];
      e_clr = h_clr[1] && !h_clr[2];
      for (int w = 0; w < 2; w++) model_step(w, e_clr, e_stp, e_sta, up_dn);
      h_sta = {h_sta[1:0], btn_start};
      h_stp = {h_stp[1:0], btn_stop};
      h_clr = {h_clr[1:0], btn_clear};
    end
    exp_q0.push_back(model_obs(0));
    exp_q1.push_back(model_obs(1));
    started = 1'b1;
  end

  task automatic compare(string name, obs_t act, obs_t exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got tens=%0d ones=%0d blank=%0b run=%0b done=%0b want tens=%0d ones=%0d blank=%0b run=%0b done=%0b",
               name, cyc_n, act.tens, act.ones, act.blank, act.running, act.done,
               exp_v.tens, exp_v.ones, exp_v.blank, exp_v.running, exp_v.done);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle and matched against the scoreboard.
  always @(negedge clk) begin
    cyc_n++;
    if (exp_q0.size() > 0) compare("nowrap", dut_obs(0), exp_q0.pop_front());
    else if (started) begin n_cmp++; n_bad++; $display("FAIL nowrap_queue_empty cyc=%0d", cyc_n); end
    if (exp_q1.size() > 0) compare("wrap", dut_obs(1), exp_q1.pop_front());
    else if (started) begin n_cmp++; n_bad++; $display("FAIL wrap_queue_empty cyc=%0d", cyc_n); end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic drive(bit s, bit p, bit c, int hold);
    btn_start = s; btn_stop = p; btn_clear = c;
    cyc(hold);
    btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
    cyc(1);
  endtask

  // Assert reset between edges and check the outputs collapse without a clock.
  task automatic async_reset_check();
    obs_t rst_obs;
    rst_obs = '{tens: 4'd0, ones: 4'd5, blank: 1'b1, running: 1'b0, done: 1'b0};
    rst = 1'b1;
    #1;
    compare("async_rst_nowrap", dut_obs(0), rst_obs);
    compare("async_rst_wrap", dut_obs(1), rst_obs);
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0; up_dn = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Up count: wrap side cycles 05..14..05, no-wrap side stops in DONE at 14.
    drive(1, 0, 0, 3);
    cyc(60);
    drive(1, 0, 0, 2); cyc(5);
    drive(0, 1, 0, 2); cyc(10);
    drive(1, 0, 0, 2); cyc(10);
    drive(0, 0, 1, 2); cyc(6);

    // Down count from 05: wrap side goes to 14, no-wrap side is DONE at 05.
    up_dn = 1'b0;
    drive(1, 0, 0, 2);
    cyc(40);
    drive(0, 0, 1, 2); cyc(4);

    // Pause around 08, hold a long time, then resume.
    up_dn = 1'b1;
    drive(1, 0, 0, 2);
    cyc(11);
    drive(0, 1, 0, 2);
    cyc(50);
    drive(1, 0, 0, 2);
    cyc(20);

    // Clear and start rising together while running.
    drive(1, 0, 1, 2);
    cyc(10);

    // Sweep stop timing so one lands on a tick edge.
    for (int d = 0; d < 4; d++) begin
      drive(0, 0, 1, 2); cyc(2);
      drive(1, 0, 0, 2);
      cyc(8 + d);
      drive(0, 1, 0, 2);
      cyc(10);
    end

    // Clear timing sweep against ticks as well.
    for (int d = 0; d < 4; d++) begin
      drive(1, 0, 0, 2);
      cyc(6 + d);
      drive(0, 0, 1, 2);
      cyc(4);
    end

    // Asynchronous reset in the middle of a run.
    drive(1, 0, 0, 2);
    cyc(9);
    async_reset_check();

    // Random button levels and direction changes.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)  btn_start = ~btn_start;
      if ($urandom_range(0, 11) == 0) btn_stop  = ~btn_stop;
      if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 19) == 0) up_dn     = ~up_dn;
      if (i == 2000) async_reset_check();
      cyc(1);
    end

    btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_count_seq_ctrl.md
Name: bcd_count_seq_ctrl

Overview:
Run/pause/clear controller for the two-digit BCD counter that drives the dual 7-segment display.
- Turns push-button inputs into control pulses and generates the count-tick prescaler internally.
- Runs an IDLE/RUN/PAUSE/DONE state machine that steps a bounded BCD count up or down.
- Outputs two BCD digits plus blank/status flags to the downstream segment decoders.

Parameters:
- TICK_DIV, 25000000, clk cycles per count tick; legal range ≥2.
- MIN_VAL, 5, lower count bound (decimal); legal range 0..98.
- MAX_VAL, 14, upper count bound (decimal); must satisfy MIN_VAL < MAX_VAL ≤ 99.
- WRAP, 1, 1 = wrap at a bound; 0 = stop in DONE at the bound.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- btn_start  in  1  start/resume button, asynchronous level
- btn_stop  in  1  pause button, asynchronous level
- btn_clear  in  1  clear button, asynchronous level
- up_dn  in  1  count direction (1 = up, 0 = down); sampled on each tick
- ones  out  4  BCD ones digit
- tens  out  4  BCD tens digit
- blank  out  1  1 = decoder must blank both digits
- running  out  1  1 while in RUN
- done  out  1  1 while in DONE

Behaviour:
- Reset (async, rst=1), all held until rst falls:
  - state = IDLE
  - tens/ones = BCD of MIN_VAL
  - blank = 1, running = 0, done = 0
  - prescaler = 0, synchroniser flops = 0
- Button conditioning:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector, giving a 1-cycle pulse.
  - Input rise to state change: 3 clk cycles.
  - A held button produces exactly one pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUN; held at 0 in every other state.
  - tick = 1 for one cycle when the prescaler equals TICK_DIV-1; the prescaler returns to 0 on the same edge.
  - First tick arrives exactly TICK_DIV cycles after entering RUN (also after PAUSE→RUN).
- Event priority in a cycle: clear > stop > start.
- State transitions:
  - IDLE: start → RUN. Digits are already MIN_VAL.
  - RUN:
    - stop → PAUSE.
    - tick with up_dn=1:
      - value < MAX_VAL: increment.
      - value == MAX_VAL and WRAP=1: load MIN_VAL.
      - value == MAX_VAL and WRAP=0: → DONE, hold MAX_VAL.
    - tick with up_dn=0: mirror of the up case (decrement; at MIN_VAL, wrap to MAX_VAL, or → DONE holding MIN_VAL).
  - PAUSE: digits frozen; start → RUN.
  - DONE: digits frozen; start and stop ignored.
  - Any state: clear → IDLE, digits = MIN_VAL, prescaler = 0.
- Simultaneous events:
  - tick + stop in RUN: count updates on that edge, state becomes PAUSE.
  - tick + clear: clear wins and the tick is discarded.
- BCD arithmetic:
  - Increment: ones 9→0 with tens+1.
  - Decrement: ones 0→9 with tens-1.
  - Digits never leave 0..9.
  - Digits never leave [MIN_VAL, MAX_VAL] after reset.
- Outputs: all registered; no combinational path from inputs.
  - blank = (state == IDLE)
  - running = (state == RUN)
  - done = (state == DONE)

Decomposition:
- Shared package bcd_disp_pkg contains:
  - state enum (IDLE, RUN, PAUSE, DONE; 2-bit)
  - bcd_digit_t (logic [3:0])
  - functions bcd_inc2 / bcd_dec2 operating on a {tens, ones} pair
  - elaboration-time parameter legality check
- One sub-module, btn_sync_edge (2-flop sync + rising-edge pulse, clk/rst), instantiated three times.

Test Plan:
All scenarios use TICK_DIV=4, MIN_VAL=5, MAX_VAL=14.
- Reset: rst=1 mid-simulation → immediately (no clk edge) tens=0, ones=5, blank=1, running=0, done=0.
- Start, up count, WRAP=1:
  - Pulse btn_start → running=1 and blank=0 three cycles later.
  - Digits then step 05,06,07,08,09,10,11,12,13,14,05, one step every 4 cycles.
  - Check the 09→10 carry.
- Down count, WRAP=1: up_dn=0 from 05 → next tick 14; from 10 → 09.
- WRAP=0, up count:
  - Reaching 14 → done=1, running=0, digits hold 14.
  - btn_start and btn_stop ignored.
  - btn_clear → IDLE with 05, blank=1.
- Pause/resume:
  - btn_stop at 08 → digits hold 08 for 50 cycles.
  - btn_start → next change to 09 exactly 4 cycles after running rises.
- Priority: btn_clear and btn_start rising in the same cycle during RUN → IDLE, 05. tick + stop on the same edge → count advances once, then PAUSE.
